// File: rtl/blok_sirala_pkg.sv
// Shared constants and types for the raster/block reorder pair (encode and decode tops).
package blok_sirala_pkg;

  localparam int unsigned GENISLIK      = 320;
  localparam int unsigned YUKSEKLIK     = 240;
  localparam int unsigned BLOK          = 8;
  localparam int unsigned BANK_DERINLIK = GENISLIK * BLOK;
  localparam int unsigned BANT_BLOK     = GENISLIK / BLOK;
  localparam int unsigned KARE_BANT     = YUKSEKLIK / BLOK;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    OKU   = 2'd1,
    BEKLE = 2'd2
  } oku_durum_e;

  // One entry of the output skid.
  typedef struct packed {
    logic [7:0] veri;
    logic       son;
    logic       resim_son;
  } cikis_t;

endpackage

// File: rtl/blok_sirala_ram.sv
// Simple dual-port RAM: one write port, one read port with one cycle of read latency.
module blok_sirala_ram #(
  parameter int unsigned V = 8,
  parameter int unsigned S = 2560,
  parameter int unsigned A = 12
) (
  input  logic         clk,
  input  logic         we,
  input  logic [A-1:0] w_adr,
  input  logic [V-1:0] w_veri,
  input  logic         re,
  input  logic [A-1:0] r_adr,
  output logic [V-1:0] r_veri
);

  logic [V-1:0] mem [S];

  always_ff @(posedge clk) begin
    if (we) mem[w_adr] <= w_veri;
    if (re) r_veri <= mem[r_adr];
  end

endmodule

// File: rtl/blok_sirala.sv
// Raster-to-block reorder: two BLOK-line banks filled in raster order, drained
// block by block through a read FSM and a 2-entry output skid.
module blok_sirala
  import blok_sirala_pkg::*;
#(
  parameter int unsigned GENISLIK  = blok_sirala_pkg::GENISLIK,
  parameter int unsigned YUKSEKLIK = blok_sirala_pkg::YUKSEKLIK,
  parameter int unsigned BLOK      = blok_sirala_pkg::BLOK
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] pix_i,
  input  logic       pix_valid_i,
  output logic       pix_ready_o,
  output logic [7:0] blk_o,
  output logic       blk_valid_o,
  input  logic       blk_ready_i,
  output logic       blk_son_o,
  output logic       resim_son_o
);

  localparam int unsigned Derinlik = GENISLIK * BLOK;
  localparam int unsigned BantBlok = GENISLIK / BLOK;
  localparam int unsigned KareBant = YUKSEKLIK / BLOK;
  localparam int unsigned XBit     = $clog2(GENISLIK);
  localparam int unsigned BBit     = $clog2(BLOK);
  localparam int unsigned BxBit    = $clog2(BantBlok);
  localparam int unsigned BantBit  = $clog2(KareBant);
  localparam int unsigned ABit     = $clog2(Derinlik);

  // Write side
  logic [XBit-1:0] wx_q;
  logic [BBit-1:0] wy_q;
  logic            wb_q;
  logic [1:0]      dolu_q, dolu_d;
  logic            yaz, bant_dolu;
  logic [ABit-1:0] yaz_adr;

  // Read side
  oku_durum_e       st_q, st_d;
  logic [BBit-1:0]  c_q, r_q;
  logic [BxBit-1:0] bx_q;
  logic [BantBit-1:0] bant_q;
  logic             rb_q;
  logic             okuma, blok_son, bant_son, resim_son;
  logic [ABit-1:0]  oku_adr;
  logic [7:0]       bank_rd [2];

  // Read in flight: data lands in the skid one cycle after issue
  logic bek_q, bek_son_q, bek_resim_q, bek_bank_q;

  // Output skid
  cikis_t     kayit_q [2];
  logic       wp_q, rp_q;
  logic [1:0] adet_q, adet_d;
  logic       cik, yer;
  cikis_t     bas;

  assign pix_ready_o = !rst_i && !dolu_q[wb_q];
  assign yaz         = pix_valid_i && pix_ready_o;
  assign bant_dolu   = yaz && (wx_q == XBit'(GENISLIK - 1)) && (wy_q == BBit'(BLOK - 1));
  assign yaz_adr     = ABit'(32'(wy_q) * GENISLIK + 32'(wx_q));

  assign blok_son  = (c_q == BBit'(BLOK - 1)) && (r_q == BBit'(BLOK - 1));
  assign bant_son  = blok_son && (bx_q == BxBit'(BantBlok - 1));
  assign resim_son = bant_son && (bant_q == BantBit'(KareBant - 1));
  assign oku_adr   = ABit'(32'(r_q) * GENISLIK + 32'(bx_q) * BLOK + 32'(c_q));

  assign blk_valid_o = (adet_q != 2'd0) && !rst_i;
  assign cik         = blk_valid_o && blk_ready_i;
  assign adet_d      = adet_q + 2'(bek_q) - 2'(cik);
  assign yer         = adet_d < 2'd2;
  assign bas         = kayit_q[rp_q];
  assign blk_o       = blk_valid_o ? bas.veri : 8'h00;
  assign blk_son_o   = blk_valid_o && bas.son;
  assign resim_son_o = blk_valid_o && bas.resim_son;

  for (genvar k = 0; k < 2; k++) begin : g_bank
    blok_sirala_ram #(
      .V(8),
      .S(Derinlik),
      .A(ABit)
    ) u_ram (
      .clk   (clk_i),
      .we    (yaz && (wb_q == 1'(k))),
      .w_adr (yaz_adr),
      .w_veri(pix_i),
      .re    (okuma && (rb_q == 1'(k))),
      .r_adr (oku_adr),
      .r_veri(bank_rd[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wx_q <= '0;
      wy_q <= '0;
      wb_q <= 1'b0;
    end else if (yaz) begin
      if (wx_q == XBit'(GENISLIK - 1)) begin
        wx_q <= '0;
        if (wy_q == BBit'(BLOK - 1)) begin
          wy_q <= '0;
          wb_q <= ~wb_q;
        end else begin
          wy_q <= wy_q + 1'b1;
        end
      end else begin
        wx_q <= wx_q + 1'b1;
      end
    end
  end

  // Set and clear never hit the same bank: the writer only fills an empty one.
  always_comb begin
    dolu_d = dolu_q;
    if (bant_dolu) dolu_d[wb_q] = 1'b1;
    if (okuma && bant_son) dolu_d[rb_q] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dolu_q <= 2'b00;
    else       dolu_q <= dolu_d;
  end

  always_comb begin
    st_d  = st_q;
    okuma = 1'b0;
    unique case (st_q)
      // Looking at the flag being set this cycle saves one cycle of first-byte latency.
      BOS: if (dolu_q[rb_q] || (bant_dolu && (wb_q == rb_q))) st_d = OKU;
      OKU: begin
        if (yer) begin
          okuma = 1'b1;
          if (bant_son) st_d = dolu_q[~rb_q] ? OKU : BOS;
        end else begin
          st_d = BEKLE;
        end
      end
      BEKLE: if (cik) st_d = OKU;
      default: st_d = BOS;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= BOS;
      c_q    <= '0;
      r_q    <= '0;
      bx_q   <= '0;
      bant_q <= '0;
      rb_q   <= 1'b0;
    end else begin
      st_q <= st_d;
      if (okuma) begin
        if (c_q == BBit'(BLOK - 1)) begin
          c_q <= '0;
          if (r_q == BBit'(BLOK - 1)) begin
            r_q <= '0;
            if (bx_q == BxBit'(BantBlok - 1)) begin
              bx_q <= '0;
              rb_q <= ~rb_q;
              if (bant_q == BantBit'(KareBant - 1)) bant_q <= '0;
              else                                   bant_q <= bant_q + 1'b1;
            end else begin
              bx_q <= bx_q + 1'b1;
            end
          end else begin
            r_q <= r_q + 1'b1;
          end
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bek_q       <= 1'b0;
      bek_son_q   <= 1'b0;
      bek_resim_q <= 1'b0;
      bek_bank_q  <= 1'b0;
    end else begin
      bek_q       <= okuma;
      bek_son_q   <= blok_son;
      bek_resim_q <= resim_son;
      bek_bank_q  <= rb_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kayit_q[0] <= '0;
      kayit_q[1] <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      adet_q     <= 2'd0;
    end else begin
      if (bek_q) begin
        kayit_q[wp_q] <= '{veri: bank_rd[bek_bank_q], son: bek_son_q, resim_son: bek_resim_q};
        wp_q          <= ~wp_q;
      end
      if (cik) rp_q <= ~rp_q;
      adet_q <= adet_d;
    end
  end

endmodule

// File: tb/tb_blok_sirala.sv
// Scoreboard bench for blok_sirala on a reduced 64x24 frame (8x8 blocks).
module tb_blok_sirala;

  localparam int TG    = 64;
  localparam int TY    = 24;
  localparam int TB    = 8;
  localparam int NBX   = TG / TB;
  localparam int NBAND = TY / TB;
  localparam int FRAME = TG * TY;
  localparam int Bant  = TG * TB;

  typedef struct {
    logic [7:0] d;
    logic       son;
    logic       rs;
  } beklenen_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] pix_i;
  logic       pix_valid_i;
  logic       pix_ready_o;
  logic [7:0] blk_o;
  logic       blk_valid_o;
  logic       blk_ready_i;
  logic       blk_son_o;
  logic       resim_son_o;

  blok_sirala #(
    .GENISLIK (TG),
    .YUKSEKLIK(TY),
    .BLOK     (TB)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .pix_i      (pix_i),
    .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o),
    .blk_o      (blk_o),
    .blk_valid_o(blk_valid_o),
    .blk_ready_i(blk_ready_i),
    .blk_son_o  (blk_son_o),
    .resim_son_o(resim_son_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;
  beklenen_t sb[$];
  beklenen_t mon_e;
  logic [7:0] img [FRAME];
  int out_log [128];
  int out_n, son_cnt, resim_cnt, resim_at;
  int seen_valid, first_valid_cyc, acc_cyc;
  logic tut;
  logic [7:0] tut_d;
  logic tut_son, tut_rs;

  function automatic void chk(input string ad, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", ad, got, want, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    blk_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       blk_ready_i = 1'b1;
        1:       blk_ready_i = 1'b0;
        default: blk_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops on every accepted output byte; checks holding while stalled.
  initial begin
    tut = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        tut = 1'b0;
      end else begin
        if (tut) begin
          chk("hold_valid", int'(blk_valid_o), 1);
          chk("hold_blk_o", int'(blk_o), int'(tut_d));
          chk("hold_son", int'(blk_son_o), int'(tut_son));
          chk("hold_resim", int'(resim_son_o), int'(tut_rs));
        end
        if (blk_valid_o && seen_valid == 0) begin
          seen_valid = 1;
          first_valid_cyc = cyc;
        end
        if (blk_valid_o && blk_ready_i) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_out: got blk_o=%0d, want no output (queue empty)", blk_o);
          end else begin
            mon_e = sb.pop_front();
            chk("blk_o", int'(blk_o), int'(mon_e.d));
            chk("blk_son_o", int'(blk_son_o), int'(mon_e.son));
            chk("resim_son_o", int'(resim_son_o), int'(mon_e.rs));
          end
          if (out_n < 128) out_log[out_n] = int'(blk_o);
          if (blk_son_o) son_cnt++;
          if (resim_son_o) begin
            resim_cnt++;
            resim_at = out_n + 1;
          end
          out_n++;
        end
        tut     = blk_valid_o && !blk_ready_i;
        tut_d   = blk_o;
        tut_son = blk_son_o;
        tut_rs  = resim_son_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_i = 1'b1;
    pix_valid_i = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_pix_ready", int'(pix_ready_o), 0);
    chk("rst_blk_valid", int'(blk_valid_o), 0);
    chk("rst_blk_o", int'(blk_o), 0);
    chk("rst_blk_son", int'(blk_son_o), 0);
    chk("rst_resim_son", int'(resim_son_o), 0);
    repeat (2) step();
    rst_i = 1'b0;
    out_n = 0;
    son_cnt = 0;
    resim_cnt = 0;
    resim_at = 0;
    seen_valid = 0;
    @(negedge clk);
    chk("post_rst_pix_ready", int'(pix_ready_o), 1);
    chk("post_rst_blk_valid", int'(blk_valid_o), 0);
    step();
  endtask

  task automatic make_ramp();
    for (int i = 0; i < FRAME; i++) img[i] = 8'(i);
  endtask

  task automatic make_random();
    for (int i = 0; i < FRAME; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  // Expected block order: band, block column, row in block, column in block.
  task automatic push_frame();
    beklenen_t e;
    for (int bd = 0; bd < NBAND; bd++)
      for (int bx = 0; bx < NBX; bx++)
        for (int r = 0; r < TB; r++)
          for (int c = 0; c < TB; c++) begin
            e.d   = img[(bd * TB + r) * TG + bx * TB + c];
            e.son = (r == TB - 1) && (c == TB - 1);
            e.rs  = e.son && (bx == NBX - 1) && (bd == NBAND - 1);
            sb.push_back(e);
          end
  endtask

  task automatic drive(input int from, input int upto, input bit rnd, input int cap,
                       output int nxt);
    int i;
    int used;
    logic acc;
    i = from;
    used = 0;
    while (i < upto && used < cap) begin
      pix_i = img[i];
      pix_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = pix_valid_i && pix_ready_o;
      step();
      used++;
      if (acc) begin
        i++;
        if (i == Bant) acc_cyc = cyc;
      end
    end
    pix_valid_i = 1'b0;
    nxt = i;
  endtask

  task automatic drain(input string ad);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      step();
      n++;
    end
    chk(ad, sb.size(), 0);
    repeat (10) step();
  endtask

  task automatic check_ramp_head(input string ad);
    int exp9 [9];
    exp9 = '{0, 1, 2, 3, 4, 5, 6, 7, 64};
    for (int k = 0; k < 9; k++) chk({ad, "_head"}, out_log[k], exp9[k]);
    chk({ad, "_block1_first"}, out_log[64], 8);
  endtask

  initial begin
    int n;
    int lat;
    rst_i = 1'b1;
    pix_valid_i = 1'b0;
    pix_i = 8'h00;
    acc_cyc = 0;
    first_valid_cyc = 0;

    // Ramp frame, downstream always ready
    do_reset();
    rdy_mode = 0;
    make_ramp();
    push_frame();
    drive(0, FRAME, 1'b0, 20000, n);
    chk("ramp_in_count", n, FRAME);
    drain("ramp_drain");
    check_ramp_head("ramp");
    chk("ramp_out_count", out_n, FRAME);
    chk("ramp_son_count", son_cnt, FRAME / 64);
    chk("ramp_resim_count", resim_cnt, 1);
    chk("ramp_resim_at", resim_at, FRAME);
    lat = first_valid_cyc - acc_cyc;
    total++;
    if (lat < 1 || lat > 3) begin
      bad++;
      $display("FAIL first_valid_latency: got %0d cycles, want 1..3", lat);
    end

    // Backpressure from reset: both banks fill, then input stalls
    do_reset();
    rdy_mode = 1;
    make_ramp();
    push_frame();
    drive(0, FRAME, 1'b0, 1200, n);
    chk("bp_accepted", n, 2 * Bant);
    @(negedge clk);
    chk("bp_pix_ready", int'(pix_ready_o), 0);
    chk("bp_blk_valid", int'(blk_valid_o), 1);
    step();
    rdy_mode = 0;
    drive(n, FRAME, 1'b0, 20000, n);
    chk("bp_in_count", n, FRAME);
    drain("bp_drain");
    chk("bp_out_count", out_n, FRAME);
    chk("bp_resim_count", resim_cnt, 1);

    // Two random frames, random valid and ready
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 2; f++) begin
      make_random();
      push_frame();
      drive(0, FRAME, 1'b1, 20000, n);
      chk("rnd_in_count", n, FRAME);
    end
    drain("rnd_drain");
    chk("rnd_out_count", out_n, 2 * FRAME);
    chk("rnd_resim_count", resim_cnt, 2);
    chk("rnd_son_count", son_cnt, 2 * FRAME / 64);

    // Reset mid-frame with a band already draining, then a clean ramp frame
    do_reset();
    rdy_mode = 0;
    make_random();
    push_frame();
    drive(0, Bant + 188, 1'b0, 20000, n);
    chk("mid_partial_in", n, Bant + 188);
    do_reset();
    make_ramp();
    push_frame();
    drive(0, FRAME, 1'b0, 20000, n);
    chk("mid_in_count", n, FRAME);
    drain("mid_drain");
    check_ramp_head("mid");
    chk("mid_out_count", out_n, FRAME);
    chk("mid_resim_at", resim_at, FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
